// File: rtl/axi4_pkg.sv
// Shared AXI4 types for the address-channel initiator.
// Address width comes from AXI4_ADDR_WIDTH (default 32 bits).
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif

package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  localparam int AXI4_4K_BYTES = 4096;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE
  } state_e;

endpackage

// File: rtl/burst_len_calc.sv
// Beat count of the next burst: bounded by remaining beats,
// MAX_LEN and the distance to the next 4 KB boundary.
module burst_len_calc
  import axi4_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MAX_LEN    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic [11:0]          cur_addr,
  input  logic [CNT_WIDTH-1:0] remaining,
  output logic [8:0]           nbeats,
  output logic [7:0]           alen
);

  localparam int SZ = $clog2(DATA_BYTES);
  localparam int CW = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  logic [12:0]   to4k;
  logic [CW-1:0] room;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] n_w;

  // Smallest of the three limits.
  always_comb begin
    to4k = (13'(AXI4_4K_BYTES) - {1'b0, cur_addr}) >> SZ;
    room = CW'(to4k);
    if (room > CW'(MAX_LEN)) room = CW'(MAX_LEN);
    rem_w  = CW'(remaining);
    n_w    = (rem_w < room) ? rem_w : room;
    nbeats = 9'(n_w);
    alen   = 8'(n_w - CW'(1));
  end

endmodule

// File: rtl/axi4_burst_issue.sv
// Splits a linear request into AXI4 INCR bursts on an AR/AW channel.
// Optional burst counter output enabled by AXI4_BURST_STAT_EN.
module axi4_burst_issue
  import axi4_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MAX_LEN    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        aclk_i,
  input  logic                        areset_i,
  input  logic [`AXI4_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CNT_WIDTH-1:0]        req_beats_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  output logic [`AXI4_ADDR_WIDTH-1:0] addr_o,
  output logic [2:0]                  asize_o,
  output logic [1:0]                  aburst_o,
  output logic [7:0]                  alen_o,
  output logic                        avalid_o,
  input  logic                        aready_i,
  output logic                        busy_o,
  output logic                        done_o
`ifdef AXI4_BURST_STAT_EN
  ,output logic [15:0]                burst_cnt_o
`endif
);

  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int SZ = $clog2(DATA_BYTES);

  state_e               state;
  state_e               state_nx;
  logic [AW-1:0]        cur_addr;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] rem_nx;
  logic [8:0]           nbeats_q;
  logic [8:0]           nbeats_c;
  logic [7:0]           alen_c;
  logic                 accept;
  logic                 hs;

  assign req_ready_o = (state == IDLE);
  assign avalid_o    = (state == ISSUE);
  assign busy_o      = (state != IDLE);
  assign asize_o     = 3'(SZ);
  assign aburst_o    = INCR;
  assign accept      = req_valid_i & req_ready_o;
  assign hs          = avalid_o & aready_i;
  assign rem_nx      = remaining - CNT_WIDTH'(nbeats_q);

  burst_len_calc #(
    .DATA_BYTES (DATA_BYTES),
    .MAX_LEN    (MAX_LEN),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_len (
    .cur_addr  (cur_addr[11:0]),
    .remaining (remaining),
    .nbeats    (nbeats_c),
    .alen      (alen_c)
  );

  // State register.
  always_ff @(posedge aclk_i) begin
    if (areset_i) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && req_beats_i != '0) state_nx = CALC;
      CALC:    state_nx = ISSUE;
      ISSUE:   if (hs) state_nx = (rem_nx == '0) ? IDLE : CALC;
      default: state_nx = IDLE;
    endcase
  end

  // Address/count tracking and burst registers.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      cur_addr  <= '0;
      remaining <= '0;
      nbeats_q  <= '0;
      addr_o    <= '0;
      alen_o    <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= (accept && req_beats_i == '0) ||
                (hs && rem_nx == '0);
      if (accept) begin
        cur_addr  <= req_addr_i & ~AW'(DATA_BYTES - 1);
        remaining <= req_beats_i;
      end
      if (state == CALC) begin
        addr_o   <= cur_addr;
        alen_o   <= alen_c;
        nbeats_q <= nbeats_c;
      end
      if (hs) begin
        cur_addr  <= cur_addr + (AW'(nbeats_q) << SZ);
        remaining <= rem_nx;
      end
    end
  end

`ifdef AXI4_BURST_STAT_EN
  // Bursts issued for the current request.
  always_ff @(posedge aclk_i) begin
    if (areset_i)    burst_cnt_o <= '0;
    else if (accept) burst_cnt_o <= '0;
    else if (hs)     burst_cnt_o <= burst_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axi4_burst_issue.sv
// Self-checking bench for axi4_burst_issue.
// Honours AXI4_BURST_STAT_EN when defined.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif

module tb_axi4_burst_issue;

  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int DB = 8;
  localparam int ML = 256;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] req_beats;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] addr;
  logic [2:0]    asize;
  logic [1:0]    aburst;
  logic [7:0]    alen;
  logic          avalid;
  logic          aready;
  logic          busy;
  logic          done;
`ifdef AXI4_BURST_STAT_EN
  logic [15:0]   burst_cnt;
`endif

  always #5 clk = ~clk;

  axi4_burst_issue #(
    .DATA_BYTES (DB),
    .MAX_LEN    (ML),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk_i      (clk),
    .areset_i    (areset),
    .req_addr_i  (req_addr),
    .req_beats_i (req_beats),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .addr_o      (addr),
    .asize_o     (asize),
    .aburst_o    (aburst),
    .alen_o      (alen),
    .avalid_o    (avalid),
    .aready_i    (aready),
    .busy_o      (busy),
    .done_o      (done)
`ifdef AXI4_BURST_STAT_EN
    ,.burst_cnt_o (burst_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] eq_addr[$];
  logic [7:0]    eq_alen[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference burst list from the splitting rules.
  function automatic void build(logic [AW-1:0] a_in, int n_in);
    logic [AW-1:0] a;
    int n, nb, to4k;
    a = a_in & ~AW'(DB - 1);
    n = n_in;
    while (n > 0) begin
      to4k = (4096 - int'(a[11:0])) / DB;
      nb = n;
      if (nb > ML) nb = ML;
      if (nb > to4k) nb = to4k;
      eq_addr.push_back(a);
      eq_alen.push_back(8'(nb - 1));
      a = a + AW'(nb * DB);
      n = n - nb;
    end
  endfunction

  task automatic run_req(logic [AW-1:0] a, int n, int stall_first);
    int budget, stall, nbursts;
    logic exp_v, pv;
    logic [AW-1:0] pa;
    logic [7:0] pl;
    build(a, n);
    nbursts = eq_addr.size();
    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_addr  = a;
    req_beats = CW'(n);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_ready", 64'(req_ready), 64'd1);
      chk("zero_avalid", 64'(avalid), 64'd0);
      @(negedge clk);
      chk("zero_done_end", 64'(done), 64'd0);
      chk("zero_avalid2", 64'(avalid), 64'd0);
      return;
    end
    chk("busy", 64'(busy), 64'd1);
    chk("ready_busy", 64'(req_ready), 64'd0);
`ifdef AXI4_BURST_STAT_EN
    chk("cnt_clr", 64'(burst_cnt), 64'd0);
`endif
    exp_v = 1'b0;
    pv = 1'b0;
    pa = '0;
    pl = '0;
    stall = stall_first;
    budget = 5000;
    while (eq_addr.size() > 0 && budget > 0) begin
      chk("avalid_seq", 64'(avalid), 64'(exp_v));
      chk("done_mid", 64'(done), 64'd0);
      if (avalid) begin
        if (pv) begin
          chk("stall_addr", 64'(addr), 64'(pa));
          chk("stall_alen", 64'(alen), 64'(pl));
        end
        if (stall > 0) begin
          aready = 1'b0;
          stall--;
        end else begin
          aready = ($urandom_range(0, 3) != 0);
        end
        if (aready) begin
          chk("addr", 64'(addr), 64'(eq_addr[0]));
          chk("alen", 64'(alen), 64'(eq_alen[0]));
          chk("asize", 64'(asize), 64'd3);
          chk("aburst", 64'(aburst), 64'd1);
          void'(eq_addr.pop_front());
          void'(eq_alen.pop_front());
          exp_v = 1'b0;
          pv = 1'b0;
        end else begin
          pa = addr;
          pl = alen;
          pv = 1'b1;
          exp_v = 1'b1;
        end
      end else begin
        aready = 1'($urandom_range(0, 1));
        exp_v = 1'b1;
        pv = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    aready = 1'b0;
    chk("bursts_left", 64'(eq_addr.size()), 64'd0);
    eq_addr.delete();
    eq_alen.delete();
    chk("done", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("ready_end", 64'(req_ready), 64'd1);
    chk("avalid_end", 64'(avalid), 64'd0);
`ifdef AXI4_BURST_STAT_EN
    chk("cnt_end", 64'(burst_cnt), 64'(nbursts));
`endif
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
`ifdef AXI4_BURST_STAT_EN
    chk("cnt_hold", 64'(burst_cnt), 64'(nbursts));
`endif
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rn, w;
    areset    = 1'b1;
    req_addr  = '0;
    req_beats = '0;
    req_valid = 1'b0;
    aready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_avalid", 64'(avalid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_alen", 64'(alen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    areset = 1'b0;

    run_req(AW'(32'h0000_0000), 600, 0);
    run_req(AW'(32'h0000_0FF0), 4, 0);
    run_req(AW'(32'h0000_2003), 1, 0);
    run_req(AW'(32'h0000_0000), 0, 0);
    run_req(AW'(32'h0000_3000), 20, 5);
    run_req(AW'(32'hFFFF_FFF8), 3, 0);

    for (int i = 0; i < 10; i++) begin
      ra = AW'($urandom);
      if ($urandom_range(0, 1) == 1)
        ra[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
      rn = $urandom_range(0, 700);
      run_req(ra, rn, $urandom_range(0, 3));
    end

    @(negedge clk);
    req_addr  = AW'(32'h0000_0100);
    req_beats = CW'(50);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!avalid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("pre_rst_avalid", 64'(avalid), 64'd1);
    aready = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    chk("mid_rst_avalid", 64'(avalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_done", 64'(done), 64'd0);
`ifdef AXI4_BURST_STAT_EN
    chk("mid_rst_cnt", 64'(burst_cnt), 64'd0);
`endif
    areset = 1'b0;

    run_req(AW'(32'h0000_5008), 9, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
